uart_frame_tx: RTL and testbench

- Transmit-side counterpart of the badge's UART frame receiver.
- Latches a multi-byte frame, for example the 18-byte flag string or a shooting-flags command frame, on a start request.
- Serialises the frame MSB-byte-first as 8N1 UART on `tx`.
- Sits between badge/challenge logic (frame source, trigger button) and the interconnect/PMOD pin driving `tx`.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_baud_tick.sv | 22 ++
 rtl/uart_frame_tx.sv | 118 +++++++++++
 tb/tb_uart_frame_tx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the badge frame transmitter and receiver.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int   OVERSAMPLE = 16;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every BR_LIMIT clocks while enabled.
module uart_baud_tick #(
  parameter int BR_LIMIT = 672,
  parameter int BR_BITS  = 10
)(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam logic [BR_BITS-1:0] DIV_LAST = BR_BITS'(BR_LIMIT - 1);

  logic [BR_BITS-1:0] div;

  always_ff @(posedge clk) begin
    if (reset || clr)  div <= '0;
    else if (en)       div <= (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  assign tick = en && (div == DIV_LAST);
endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART frame transmitter, highest byte first, 8N1 on tx.
// Define UART_FRAME_TX_PARITY_EN to append an even-parity bit to each byte.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int  FRAME_BYTES = 18,
  parameter int  DBITS       = 8,
  parameter int  BR_LIMIT    = 672,
  parameter int  BR_BITS     = 10,
  parameter int  OVERSAMPLE  = uart_pkg::OVERSAMPLE,
  localparam int IDXW        = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [FRAME_BYTES*DBITS-1:0] frame_in,
  output logic                         tx,
  output logic                         busy,
  output logic                         done,
  output logic [IDXW-1:0]              byte_idx
);
  localparam int FW  = FRAME_BYTES * DBITS;
  localparam int BW  = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam int OSW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [BW-1:0]   BIT_LAST  = BW'(DBITS - 1);
  localparam logic [OSW-1:0]  OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [IDXW-1:0] BYTE_LAST = IDXW'(FRAME_BYTES - 1);

  state_t            state, state_nx;
  logic              start_q;
  logic [FW-1:0]     frame_q;
  logic [OSW-1:0]    os_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              tick, bit_end, accept, last_byte;
  logic [DBITS-1:0]  cur_byte;

  assign accept    = (state == IDLE) && start && !start_q;
  assign bit_end   = tick && (os_cnt == OS_LAST);
  assign last_byte = (byte_idx == BYTE_LAST);
  assign cur_byte  = frame_q[FW-1 -: DBITS];

  uart_baud_tick #(.BR_LIMIT(BR_LIMIT), .BR_BITS(BR_BITS)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (busy),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = START;
      START: if (bit_end) state_nx = DATA;
`ifdef UART_FRAME_TX_PARITY_EN
      DATA:   if (bit_end && bit_cnt == BIT_LAST) state_nx = PARITY;
      PARITY: if (bit_end) state_nx = STOP;
`else
      DATA:  if (bit_end && bit_cnt == BIT_LAST) state_nx = STOP;
`endif
      STOP:  if (bit_end) state_nx = last_byte ? IDLE : START;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tx   = IDLE_LEVEL;
    busy = (state != IDLE);
    case (state)
      START:  tx = 1'b0;
      DATA:   tx = cur_byte[bit_cnt];
`ifdef UART_FRAME_TX_PARITY_EN
      PARITY: tx = ^cur_byte;
`endif
      default: tx = IDLE_LEVEL;
    endcase
  end

  // Datapath: frame shifts up one byte at each inter-byte stop boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q  <= 1'b0;
      done     <= 1'b0;
      frame_q  <= '0;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
    end else begin
      start_q <= start;
      done    <= (state == STOP) && bit_end && last_byte;
      if (accept) begin
        frame_q  <= frame_in;
        os_cnt   <= '0;
        bit_cnt  <= '0;
        byte_idx <= '0;
      end else if (busy && tick) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        if (bit_end) begin
          if (state == DATA)
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
          if (state == STOP) begin
            if (last_byte) begin
              byte_idx <= '0;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              frame_q  <= frame_q << DBITS;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Randomized bench for uart_frame_tx against a bit-sequence reference model.
module tb_uart_frame_tx;
  localparam int FB   = 2;
  localparam int DB   = 8;
  localparam int BRL  = 4;
  localparam int OS   = 16;
  localparam int FW   = FB * DB;
  localparam int BITC = OS * BRL;
`ifdef UART_FRAME_TX_PARITY_EN
  localparam int BPB  = DB + 3;
`else
  localparam int BPB  = DB + 2;
`endif
  localparam int FT   = FB * BPB * BITC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [FW-1:0] frame_in = '0;
  logic          tx, busy, done;
  logic [0:0]    byte_idx;

  int checks = 0;
  int failures = 0;

  uart_frame_tx #(.FRAME_BYTES(FB), .DBITS(DB), .BR_LIMIT(BRL), .BR_BITS(2), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .start(start), .frame_in(frame_in),
    .tx(tx), .busy(busy), .done(done), .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_idx", byte_idx, 0);
      step();
    end
  endtask

  // Expected line: per byte (highest first) start 0, data LSB first, [parity], stop 1.
  task automatic run_frame(input logic [FW-1:0] f, input bit hold, input int rise2_at,
                           input int rst_at, input bit rise_at_done);
    bit q[$];
    logic [DB-1:0] b;
    for (int k = FB - 1; k >= 0; k--) begin
      b = f[k*DB +: DB];
      q.push_back(1'b0);
      for (int i = 0; i < DB; i++) q.push_back(b[i]);
`ifdef UART_FRAME_TX_PARITY_EN
      q.push_back(^b);
`endif
      q.push_back(1'b1);
    end
    frame_in = f;
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    frame_in = FW'($urandom);
    for (int c = 0; c < FT; c++) begin
      chk("tx", tx, q[c / BITC]);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("byte_idx", byte_idx, c / (BPB * BITC));
      if (c == rst_at) begin
        reset = 1'b1;
        step();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        return;
      end
      if (c == rise2_at) start = 1'b1;
      if (c == rise2_at + 1 && !hold) start = 1'b0;
      if (c % 97 == 5) frame_in = FW'($urandom);
      if (rise_at_done && c == FT - 1) start = 1'b1;
      step();
    end
    chk("done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_tx", tx, 1);
    step();
    chk("done_once", done, 0);
  endtask

  initial begin
    step(); step();
    chk("rst_tx0", tx, 1);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_idx0", byte_idx, 0);
    reset = 1'b0;
    idle_chk(200);

    run_frame(16'h4160, 0, -1, -1, 0);
    idle_chk(20);
    run_frame(16'h4143, 0, -1, -1, 0);
    idle_chk(20);

    // Held start: exactly one frame, then quiet while still held.
    run_frame(FW'($urandom), 1, -1, -1, 0);
    idle_chk(3000 - FT - 2);
    start = 1'b0;
    idle_chk(5);

    // Rise during a frame is dropped, not queued.
    run_frame(FW'($urandom), 0, 300, -1, 0);
    idle_chk(300);
    run_frame(FW'($urandom), 0, -1, -1, 0);
    idle_chk(10);

    // Reset mid-frame, then a complete fresh frame.
    run_frame(FW'($urandom), 0, -1, 700, 0);
    idle_chk(200);
    run_frame(FW'($urandom), 0, -1, -1, 0);
    idle_chk(10);

    // Rise coinciding with the final stop edge is ignored; next rise works.
    run_frame(FW'($urandom), 0, -1, -1, 1);
    idle_chk(50);
    start = 1'b0;
    idle_chk(3);

    for (int n = 0; n < 3; n++) begin
      run_frame(FW'($urandom), 0, -1, -1, 0);
      idle_chk($urandom_range(1, 40));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
